// File: rtl/tiny8_mem_ctrl.sv
// tiny8 memory controller: one request at a time, WAIT_STATES idle cycles,
// then a single access to a 1-cycle-latency synchronous SRAM and a one-cycle mem_resp.
module tiny8_mem_ctrl #(
  parameter int WAIT_STATES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic [7:0] mem_address,
  input  logic [7:0] mem_wdata,
  output logic [7:0] mem_rdata,
  output logic       mem_resp,
  output logic       mem_err,
  output logic       sram_cs,
  output logic       sram_we,
  output logic [7:0] sram_addr,
  output logic [7:0] sram_wdata,
  input  logic [7:0] sram_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    CAPTURE,
    RESP
  } state_t;

  // Only used when WAIT_STATES > 0, so the wrap at zero never matters.
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       op_write;
  logic [7:0] addr_q, wdata_q;
  logic       req;

  assign req = mem_read | mem_write;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_write  <= 1'b0;
      addr_q    <= 8'h00;
      wdata_q   <= 8'h00;
      mem_rdata <= 8'h00;
      mem_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && req) begin
        // Write wins a simultaneous request; the conflict is remembered until reset.
        op_write <= mem_write;
        addr_q   <= mem_address;
        wdata_q  <= mem_wdata;
        if (mem_read && mem_write) mem_err <= 1'b1;
      end
      if (state == CAPTURE && !op_write) mem_rdata <= sram_rdata;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sram_cs   = 1'b0;
    sram_we   = 1'b0;
    mem_resp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = ACCESS;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = ACCESS;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ACCESS: begin
        sram_cs   = 1'b1;
        sram_we   = op_write;
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = RESP;
      RESP: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_tiny8_mem_ctrl.sv
// Bench for tiny8_mem_ctrl: two instances (WAIT_STATES=2 and 0), each with a
// behavioural SRAM; table vectors, hand-written corner sequences, and random traffic.
module tb_tiny8_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s[2];
  logic       mem_read_s[2];
  logic       mem_write_s[2];
  logic [7:0] addr_s[2];
  logic [7:0] wdata_s[2];
  logic [7:0] rdata_s[2];
  logic       resp_s[2];
  logic       err_s[2];
  logic       cs_s[2];
  logic       we_s[2];
  logic [7:0] saddr_s[2];
  logic [7:0] swdata_s[2];

  logic       pl_en;
  logic [7:0] pl_addr, pl_data;

  for (genvar g = 0; g < 2; g++) begin : inst
    logic [7:0] srd;
    logic [7:0] mem [256];

    tiny8_mem_ctrl #(.WAIT_STATES(g == 0 ? 2 : 0)) dut (
      .clk        (clk),
      .rst        (rst_s[g]),
      .mem_read   (mem_read_s[g]),
      .mem_write  (mem_write_s[g]),
      .mem_address(addr_s[g]),
      .mem_wdata  (wdata_s[g]),
      .mem_rdata  (rdata_s[g]),
      .mem_resp   (resp_s[g]),
      .mem_err    (err_s[g]),
      .sram_cs    (cs_s[g]),
      .sram_we    (we_s[g]),
      .sram_addr  (saddr_s[g]),
      .sram_wdata (swdata_s[g]),
      .sram_rdata (srd)
    );

    // Synchronous single-port SRAM, read data one cycle after cs; ignores rst.
    always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (cs_s[g]) begin
        if (we_s[g]) mem[saddr_s[g]] <= swdata_s[g];
        else         srd <= mem[saddr_s[g]];
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int ws_of(input int w);
    return (w == 0) ? 2 : 0;
  endfunction

  // Reference model: memory contents and the last value a read returned.
  logic [7:0] model_mem[2][256];
  logic [7:0] last_rd[2];

  function automatic logic [7:0] model_apply(input int w, input bit wr,
                                             input logic [7:0] a, input logic [7:0] d);
    if (wr) model_mem[w][a] = d;
    else    last_rd[w] = model_mem[w][a];
    return last_rd[w];
  endfunction

  // Issue one request from the middle of an IDLE cycle (c0), hold it until
  // mem_resp, and return observations indexed in cycles after c0.
  task automatic run_req(input int w, input bit rd, input bit wr,
                         input logic [7:0] a, input logic [7:0] d, input bit perturb,
                         output int lat, output int cs_n, output int cs_k,
                         output logic cs_we, output logic [7:0] cs_a, output logic [7:0] cs_d,
                         output logic [7:0] rdat, output logic err);
    lat = -1; cs_n = 0; cs_k = -1; cs_we = 1'b0; cs_a = 8'h00; cs_d = 8'h00;
    rdat = 8'h00; err = 1'b0;
    mem_read_s[w]  = rd;
    mem_write_s[w] = wr;
    addr_s[w]      = a;
    wdata_s[w]     = d;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (perturb && k == 1) begin
        addr_s[w]  = a + 8'd1;
        wdata_s[w] = ~d;
      end
      if (cs_s[w]) begin
        cs_n++; cs_k = k; cs_we = we_s[w]; cs_a = saddr_s[w]; cs_d = swdata_s[w];
      end
      if (resp_s[w]) begin
        lat = k; rdat = rdata_s[w]; err = err_s[w];
      end
    end
    mem_read_s[w]  = 1'b0;
    mem_write_s[w] = 1'b0;
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_s[w]), 32'd0);
    check("rdata_stable", 32'(rdata_s[w]), 32'(rdat));
  endtask

  task automatic check_req(input string name, input int w, input bit rd, input bit wr,
                           input logic [7:0] a, input logic [7:0] d, input bit perturb,
                           input logic [7:0] exp_rd, input bit exp_err);
    int lat, cs_n, cs_k;
    logic cs_we, err;
    logic [7:0] cs_a, cs_d, rdat, unused_model;
    run_req(w, rd, wr, a, d, perturb, lat, cs_n, cs_k, cs_we, cs_a, cs_d, rdat, err);
    unused_model = model_apply(w, wr, a, d);
    check({name, "_latency"}, 32'(lat), 32'(3 + ws_of(w)));
    check({name, "_cs_count"}, 32'(cs_n), 32'd1);
    check({name, "_cs_cycle"}, 32'(cs_k), 32'(1 + ws_of(w)));
    check({name, "_we"}, 32'(cs_we), 32'(wr));
    check({name, "_addr"}, 32'(cs_a), 32'(a));
    if (wr) check({name, "_wdata"}, 32'(cs_d), 32'(d));
    check({name, "_rdata"}, 32'(rdat), 32'(exp_rd));
    check({name, "_err"}, 32'(err), 32'(exp_err));
  endtask

  typedef struct {
    bit         rd;
    bit         wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp_rdata;
    bit         exp_err;
  } vec_t;

  vec_t tbl[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int resp_k[$];
    int prev_resp;
    int bad;
    logic [7:0] exp;

    // Expected values: preload pattern a*5+1 except 0x10=A5, 0x11=5A.
    tbl[0] = '{1, 0, 8'h10, 8'h00, 8'hA5, 0};
    tbl[1] = '{0, 1, 8'h20, 8'h3C, 8'hA5, 0};
    tbl[2] = '{1, 0, 8'h20, 8'h00, 8'h3C, 0};
    tbl[3] = '{1, 0, 8'hFF, 8'h00, 8'hFC, 0};
    tbl[4] = '{0, 1, 8'hFF, 8'h81, 8'hFC, 0};
    tbl[5] = '{1, 0, 8'hFF, 8'h00, 8'h81, 0};
    tbl[6] = '{1, 1, 8'h05, 8'h77, 8'h81, 1};
    tbl[7] = '{1, 0, 8'h05, 8'h00, 8'h77, 1};

    for (int w = 0; w < 2; w++) begin
      rst_s[w] = 1'b1; mem_read_s[w] = 1'b0; mem_write_s[w] = 1'b0;
      addr_s[w] = 8'h00; wdata_s[w] = 8'h00; last_rd[w] = 8'h00;
    end
    pl_en = 1'b1;
    for (int a = 0; a < 256; a++) begin
      pl_addr = 8'(a);
      pl_data = (a == 16) ? 8'hA5 : (a == 17) ? 8'h5A : 8'(a * 5 + 1);
      model_mem[0][a] = pl_data;
      model_mem[1][a] = pl_data;
      @(negedge clk);
    end
    pl_en = 1'b0;

    for (int w = 0; w < 2; w++) begin
      check("rst_rdata", 32'(rdata_s[w]), 32'h00);
      check("rst_resp", 32'(resp_s[w]), 32'd0);
      check("rst_err", 32'(err_s[w]), 32'd0);
      check("rst_cs", 32'(cs_s[w]), 32'd0);
      check("rst_we", 32'(we_s[w]), 32'd0);
      check("rst_saddr", 32'(saddr_s[w]), 32'h00);
      check("rst_swdata", 32'(swdata_s[w]), 32'h00);
      rst_s[w] = 1'b0;
    end
    @(negedge clk);

    // Table vectors on the WAIT_STATES=2 instance.
    for (int i = 0; i < 8; i++)
      check_req($sformatf("tbl%0d", i), 0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0,
                tbl[i].exp_rdata, tbl[i].exp_err);

    // Address/data changed during WAIT: the access must still use 0x10.
    check_req("perturb", 0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b1);

    // Reset during WAIT of a read: no access, no response, reset values next cycle.
    mem_read_s[0] = 1'b1; addr_s[0] = 8'h10;
    @(negedge clk);
    check("rstwait_cs_wait", 32'(cs_s[0]), 32'd0);
    rst_s[0] = 1'b1;
    @(negedge clk);
    rst_s[0] = 1'b0; mem_read_s[0] = 1'b0;
    check("rstwait_rdata", 32'(rdata_s[0]), 32'h00);
    check("rstwait_err", 32'(err_s[0]), 32'd0);
    check("rstwait_saddr", 32'(saddr_s[0]), 32'h00);
    check("rstwait_swdata", 32'(swdata_s[0]), 32'h00);
    check("rstwait_we", 32'(we_s[0]), 32'd0);
    bad = 0;
    for (int k = 0; k < 6; k++) begin
      if (cs_s[0] || resp_s[0]) bad++;
      @(negedge clk);
    end
    check("rstwait_quiet", 32'(bad), 32'd0);
    last_rd[0] = 8'h00;
    check_req("after_rst", 0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, 1'b0);

    // WAIT_STATES=0, read of 0x30 held for 10 cycles: responses at c0+3, c0+7,
    // and c0+11 for the access re-sampled in the IDLE cycle c0+8.
    mem_read_s[1] = 1'b1; addr_s[1] = 8'h30;
    prev_resp = 0; bad = 0;
    for (int k = 0; k < 14; k++) begin
      if (k == 10) mem_read_s[1] = 1'b0;
      if (resp_s[1]) begin
        resp_k.push_back(k);
        if (prev_resp != 0) bad++;
        if (rdata_s[1] !== model_mem[1][8'h30]) bad++;
      end
      prev_resp = int'(resp_s[1]);
      @(negedge clk);
    end
    last_rd[1] = model_mem[1][8'h30];
    check("held_resp_count", 32'(resp_k.size()), 32'd3);
    if (resp_k.size() == 3) begin
      check("held_resp0", 32'(resp_k[0]), 32'd3);
      check("held_resp1", 32'(resp_k[1]), 32'd7);
      check("held_resp2", 32'(resp_k[2]), 32'd11);
    end
    check("held_no_consec_or_bad_data", 32'(bad), 32'd0);

    // Random traffic on both instances against the reference model.
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 30; n++) begin
        bit wr;
        logic [7:0] a, d;
        wr = 1'($urandom_range(0, 1));
        a  = (n % 7 == 0) ? 8'hFF : 8'(8'h40 + $urandom_range(0, 7));
        d  = 8'($urandom);
        exp = wr ? last_rd[w] : model_mem[w][a];
        check_req($sformatf("rnd_w%0d_%0d", w, n), w, !wr, wr, a, d, 1'b0, exp, 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tiny8_mem_ctrl.md
# tiny8_mem_ctrl

Memory controller sitting directly downstream of the tiny8 datapath. Accepts a read or write request built from the datapath's MAR (`mem_address`) and MDR (`mem_wdata`), runs a single access to an external synchronous single-port SRAM after a programmable number of wait states, and returns `mem_rdata` with a one-cycle `mem_resp` pulse that the control FSM uses to advance.

## Interface

- `WAIT_STATES`, default 2: idle cycles inserted before each SRAM access, legal range 0..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_read`  in  1  read request; held by the requester until `mem_resp`.
- `mem_write`  in  1  write request; held by the requester until `mem_resp`.
- `mem_address`  in  8  access address (tiny8_word).
- `mem_wdata`  in  8  write data (tiny8_word).
- `mem_rdata`  out  8  read data, registered.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  sticky flag: `mem_read` and `mem_write` were sampled high together.
- `sram_cs`  out  1  SRAM chip select, one cycle per access.
- `sram_we`  out  1  SRAM write enable, valid only with `sram_cs`.
- `sram_addr`  out  8  SRAM address.
- `sram_wdata`  out  8  SRAM write data.
- `sram_rdata`  in  8  SRAM read data, valid the cycle after a read `sram_cs` (1-cycle latency).

## Operation

- States: IDLE, WAIT, ACCESS, CAPTURE, RESP.
- IDLE: if `mem_read | mem_write`, latch address, wdata, and op (write wins when both are high, and `mem_err` is set). Go to WAIT with counter = `WAIT_STATES`-1 when `WAIT_STATES`>0; otherwise go straight to ACCESS.
- WAIT: decrement the 4-bit counter; go to ACCESS when the counter is 0.
- ACCESS: `sram_cs`=1, `sram_we`=latched op, `sram_addr`/`sram_wdata` from the latches. Then go to CAPTURE.
- CAPTURE: on a read, register `sram_rdata` into `mem_rdata` at the end of this cycle. On a write, `mem_rdata` is unchanged. Then go to RESP.
- RESP: `mem_resp`=1 for exactly this cycle. Then go unconditionally to IDLE.
- Request inputs are ignored outside IDLE. Changes to address, data, or op mid-access have no effect.
- `sram_addr`/`sram_wdata` show the latched values at all times. They are only meaningful in ACCESS.
- `mem_rdata` holds the last read value across writes and idle periods.
- `mem_err` is cleared only by `rst`.

## Timing

- Reset values: state IDLE, `mem_rdata`=0x00, `mem_resp`=0, `mem_err`=0, `sram_cs`=0, `sram_we`=0, `sram_addr`=0x00, `sram_wdata`=0x00, counter 0.
- Request high in IDLE at cycle c0:
  - ACCESS in cycle c0+1+`WAIT_STATES`.
  - CAPTURE one cycle later.
  - `mem_resp` in cycle c0+3+`WAIT_STATES`.
  - Latency: 3+`WAIT_STATES` cycles (5 at the default).
- `mem_rdata` is valid in the RESP cycle and remains stable afterwards.
- The requester drops or changes its request on the edge that ends RESP. The mandatory IDLE cycle after RESP prevents a held request from being re-sampled. Back-to-back throughput is one access per 4+`WAIT_STATES` cycles.
- `rst` in any state:
  - Next cycle is IDLE with reset values.
  - An in-flight access is abandoned and no `mem_resp` is issued.
  - An SRAM write whose ACCESS cycle coincides with `rst` still lands. The cs/we being sampled that cycle is accepted.
- Address 0xFF has no special handling. There is no wrap logic.

## Test plan

- Reset, then a read of 0x10 (SRAM preloaded 0x10=0xA5), `WAIT_STATES`=2 -> `sram_cs`=1/`sram_we`=0 in cycle c0+3; `mem_resp`=1 only in c0+5 with `mem_rdata`=0xA5; `mem_rdata` still 0xA5 afterwards.
- Write 0x3C to 0x20, then read 0x20 -> single `sram_we` pulse with addr 0x20 and data 0x3C; the read returns 0x3C; `mem_rdata` is unchanged during the write's RESP.
- `WAIT_STATES`=0, a read held continuously for 10 cycles -> `mem_resp` in c0+3 and again in c0+7; there is never a `mem_resp` in consecutive cycles.
- `mem_read` and `mem_write` both high, addr 0x05, wdata 0x77 -> a write is performed; `mem_err`=1 and stays 1 after later clean accesses until `rst`.
- `rst` asserted during WAIT of a read -> no `sram_cs`, no `mem_resp`; all outputs at reset values the next cycle; a new read completes normally.
- Address/data changed during WAIT (0x10 to 0x11) -> the access uses 0x10.
